dot_sequencer: RTL and testbench
================================

# dot_sequencer

Control stage that sits directly upstream of the minifloat MAC in the TPU datapath. It buffers incoming operand pairs and streams them into the MAC one per cycle. It clears the MAC accumulator between jobs, then reads the 32-bit accumulator back through the MAC's 16-bit half-select port and presents it as a single result word behind a valid/ready handshake.

## Interface
- DEPTH, 16: operand FIFO entries (power of two, ≥2)
- LEN_W, 8: width of per-job pair counter
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- s_valid  in  1  operand pair valid
- s_ready  out  1  FIFO can accept (= !full)
- s_a, s_b  in  8 each  minifloat operands {sign, exp[3:0], man[2:0]}
- s_last  in  1  pair is final one of job
- mac_reset  out  1  MAC accumulator clear
- mac_a, mac_b  out  8 each  MAC operand inputs
- mac_out_hl  out  1  MAC half select (0 = [15:0], 1 = [31:16])
- mac_out  in  16  MAC selected half
- mac_error  in  1  MAC error flag
- r_valid  out  1  result valid
- r_ready  in  1  result accepted
- r_data  out  32  accumulated dot product, two's complement
- r_count  out  LEN_W  pairs issued in job, wraps mod 2^LEN_W
- r_error  out  1  mac_error seen at any point during job (sticky per job)

## Operation
- Each FIFO entry is {a, b, last}, 17 bits. Push when s_valid && s_ready. FIFO accepts in every state, so the next job is buffered during readout.
- mac_a/mac_b = 8'h00 whenever no pair is being issued. A 00×00 product contributes 0 to the accumulator, so bubbles are harmless.
- mac_reset = reset | (state == CLEAR).
- States:
  - CLEAR (1 cycle): clear counters and r_error. Go to RUN.
  - RUN: if FIFO is non-empty, pop one entry, drive it on mac_a/mac_b, and increment count. If the popped entry has last=1, go to RD_HI. If FIFO is empty, drive zeros and stay.
  - RD_HI: mac_out_hl=1; at end of cycle capture mac_out into r_data[31:16]. Go to RD_LO.
  - RD_LO: mac_out_hl=0; at end of cycle capture mac_out into r_data[15:0]. Go to DONE.
  - DONE: r_valid=1; r_data, r_count and r_error are held stable. On r_ready, go to CLEAR.
- MAC contract:
  - The MAC's out port refreshes only on an out_hl transition. mac_out_hl therefore idles at 0 and always toggles 0→1→0 per readout.
  - A pair driven in cycle t is in the accumulator after the edge ending t.
- r_error ORs in mac_error each cycle from CLEAR through RD_LO.

## Timing
- Reset: state CLEAR, FIFO empty, s_ready=0 during reset, r_valid=0, r_data=0, r_count=0, r_error=0, mac_out_hl=0, mac_a=mac_b=0, mac_reset=1.
- Pop of last pair in cycle t gives RD_HI at t+1, RD_LO at t+2, and r_valid high from t+3.
- Result handshake completes on the edge where r_valid && r_ready. CLEAR follows on the next cycle, then RUN. Job-to-job overhead is 4 cycles plus handshake wait.
- Simultaneous push and pop in RUN are allowed. Full status uses the pre-edge count, so s_ready=0 at full even while popping.
- Reset mid-job: FIFO is flushed, the partial accumulator is cleared via mac_reset, and no partial result is emitted.
- A job of 2^LEN_W pairs reports r_count=0. No error is raised for this.

## Structure
- Shared package tpu_pkg:
  - seq_state_e enum {CLEAR, RUN, RD_HI, RD_LO, DONE}
  - MF_ZERO = 8'h00
  - MF_W = 8
  - ACC_W = 32
  - HALF_W = 16
- One sub-module: sync_fifo, parameterised by width (17) and DEPTH, with a count-based full/empty flag. The rest is the FSM plus result registers in dot_sequencer.

## Test plan
- Reset, then push 08×08 with last=1. Require r_data=0x00000040, r_count=1, r_valid 3 cycles after the pop, mac_out_hl sequence 0,1,0.
- Job {08×08, 10×08, 88×08 last}. Require r_data=0x00000080 (64+128−64), r_count=3, r_error=0.
- 7F×7F with last=1. Require r_data=0x10000000, which checks capture of the high half.
- Two jobs back-to-back with r_ready held low 20 cycles. Require:
  - s_ready drops at DEPTH entries with no pair lost;
  - second result equals its own dot product, proving the clear between jobs.
- Reset asserted in RUN with 3 entries buffered. Require FIFO empty, r_valid=0, and the next single-pair job 08×08 returning 0x40.
- s_valid with 5-cycle gaps between pairs of the second scenario's job. Require the identical result 0x00000080 and r_count=3.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU datapath types: sequencer states, minifloat and
// accumulator widths, and the buffered operand pair layout.
package tpu_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    RUN,
    RD_HI,
    RD_LO,
    DONE
  } seq_state_e;

  localparam int MF_W   = 8;
  localparam int ACC_W  = 32;
  localparam int HALF_W = 16;

  localparam logic [MF_W-1:0] MF_ZERO = 8'h00;

  typedef struct packed {
    logic [MF_W-1:0] a;
    logic [MF_W-1:0] b;
    logic            last;
  } pair_t;

endpackage

// File: rtl/dot_sequencer_if.sv
// Operand stream in, result word out; the producer/consumer side
// is master, the sequencer is slave.
interface dot_sequencer_if #(
  parameter int LEN_W = 8
);
  import tpu_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [MF_W-1:0]   s_a;
  logic [MF_W-1:0]   s_b;
  logic              s_last;

  logic              r_valid;
  logic              r_ready;
  logic [ACC_W-1:0]  r_data;
  logic [LEN_W-1:0]  r_count;
  logic              r_error;

  modport master (
    output s_valid, s_a, s_b, s_last, r_ready,
    input  s_ready, r_valid, r_data, r_count, r_error
  );

  modport slave (
    input  s_valid, s_a, s_b, s_last, r_ready,
    output s_ready, r_valid, r_data, r_count, r_error
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; full/empty derive from an
// occupancy count so all DEPTH slots are usable.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dot_sequencer.sv
// Streams buffered operand pairs into the minifloat MAC, then reads
// the accumulator back in two halves as one result word.
module dot_sequencer
  import tpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  dot_sequencer_if.slave    bus,
  output logic              mac_reset,
  output logic [MF_W-1:0]   mac_a,
  output logic [MF_W-1:0]   mac_b,
  output logic              mac_out_hl,
  input  logic [HALF_W-1:0] mac_out,
  input  logic              mac_error
);
  localparam int PW = $bits(pair_t);

  seq_state_e       state;
  seq_state_e       state_n;
  pair_t            in_pair;
  pair_t            head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ACC_W-1:0] data_q;
  logic [LEN_W-1:0] count_q;
  logic             error_q;

  assign in_pair     = '{a: bus.s_a, b: bus.s_b, last: bus.s_last};
  assign bus.s_ready = !reset && !full;
  assign push        = bus.s_valid && bus.s_ready;
  assign pop         = !reset && state == RUN && !empty;

  sync_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_pair),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Idle operands are zero so bubbles add nothing to the accumulator.
  assign mac_a       = pop ? head.a : MF_ZERO;
  assign mac_b       = pop ? head.b : MF_ZERO;
  assign mac_reset   = reset || state == CLEAR;
  assign mac_out_hl  = !reset && state == RD_HI;
  assign bus.r_valid = !reset && state == DONE;
  assign bus.r_data  = data_q;
  assign bus.r_count = count_q;
  assign bus.r_error = error_q;

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      CLEAR:   state_n = RUN;
      RUN:     if (pop && head.last) state_n = RD_HI;
      RD_HI:   state_n = RD_LO;
      RD_LO:   state_n = DONE;
      DONE:    if (bus.r_ready) state_n = CLEAR;
      default: state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          count_q <= '0;
          error_q <= mac_error;
        end
        RUN: begin
          if (pop) count_q <= count_q + 1'b1;
          error_q <= error_q | mac_error;
        end
        RD_HI: begin
          data_q[ACC_W-1:HALF_W] <= mac_out;
          error_q <= error_q | mac_error;
        end
        RD_LO: begin
          data_q[HALF_W-1:0] <= mac_out;
          error_q <= error_q | mac_error;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_sequencer.sv
// Bench for dot_sequencer with a behavioural minifloat MAC and a
// job-level dot-product reference.
module tb_dot_sequencer;
  import tpu_pkg::*;

  localparam int DEPTH = 16;
  localparam int LEN_W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mac_reset;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic        mac_out_hl;
  logic [15:0] mac_out;
  logic        mac_error;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  always #5 clk = ~clk;

  dot_sequencer_if #(.LEN_W(LEN_W)) bus ();

  dot_sequencer #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .mac_reset  (mac_reset),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_out_hl (mac_out_hl),
    .mac_out    (mac_out),
    .mac_error  (mac_error)
  );

  // Minifloat product as a scaled integer: exp 0 is subnormal
  // (no hidden bit, exponent 1), products scaled so 1.0*1.0 = 64.
  function automatic logic [31:0] mf_prod(input logic [7:0] a,
                                          input logic [7:0] b);
    int ea, eb, ma, mb;
    longint p;
    ea = (a[6:3] == 4'd0) ? 1 : int'(a[6:3]);
    eb = (b[6:3] == 4'd0) ? 1 : int'(b[6:3]);
    ma = (a[6:3] == 4'd0) ? int'(a[2:0]) : 8 + int'(a[2:0]);
    mb = (b[6:3] == 4'd0) ? int'(b[2:0]) : 8 + int'(b[2:0]);
    p = longint'(ma * mb) <<< (ea + eb - 2);
    if (a[7] ^ b[7]) p = -p;
    return p[31:0];
  endfunction

  // MAC model: out only refreshes when out_hl changes.
  logic [31:0] acc;
  logic        hl_q;
  logic [15:0] out_q;

  always @(posedge clk) begin
    if (mac_reset) acc <= '0;
    else           acc <= acc + mf_prod(mac_a, mac_b);
    hl_q  <= mac_out_hl;
    out_q <= mac_out;
  end

  assign mac_out = (mac_out_hl != hl_q)
                 ? (mac_out_hl ? acc[31:16] : acc[15:0])
                 : out_q;

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b,
                           input logic last);
    bit done;
    done = 0;
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    bus.s_last  = last;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    bus.s_valid = 1'b0;
    if (done) n_acc++;
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: s_ready stayed 0, want 1");
    end
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = bus.r_valid;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: r_valid=0 after %0d cycles, want 1",
               budget);
    end
  endtask

  task automatic accept();
    bus.r_ready = 1'b1;
    @(posedge clk);
    #1 bus.r_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_s_ready: got %b want 0", bus.s_ready);
    end
    n_checks++;
    if (bus.r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_r_valid: got %b want 0", bus.r_valid);
    end
    n_checks++;
    if (bus.r_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_r_data: got %h want 0", bus.r_data);
    end
    n_checks++;
    if (bus.r_count !== 8'd0 || bus.r_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cnt_err: got %0d/%b want 0/0",
               bus.r_count, bus.r_error);
    end
    n_checks++;
    if (mac_a !== 8'h0 || mac_b !== 8'h0 || mac_out_hl !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mac_in: got %h %h %b want 00 00 0",
               mac_a, mac_b, mac_out_hl);
    end
    n_checks++;
    if (mac_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mac_reset: got %b want 1", mac_reset);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] hl_seq;
    logic [3:0] rv_seq;
    logic [7:0] a_pop;
    push_pair(8'h08, 8'h08, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      hl_seq[k] = mac_out_hl;
      rv_seq[k] = bus.r_valid;
      if (k == 0) a_pop = mac_a;
    end
    n_checks++;
    if (a_pop !== 8'h08) begin
      n_fail++;
      $display("FAIL single_issue: mac_a got %h want 08", a_pop);
    end
    n_checks++;
    if (hl_seq[2:0] !== 3'b010) begin
      n_fail++;
      $display("FAIL single_hl_seq: got %b want 010 (lsb first)",
               hl_seq[2:0]);
    end
    n_checks++;
    if (rv_seq !== 4'b1000) begin
      n_fail++;
      $display("FAIL single_latency: r_valid seq %b want 1000", rv_seq);
    end
    n_checks++;
    if (bus.r_data !== 32'h40 || bus.r_count !== 8'd1) begin
      n_fail++;
      $display("FAIL single_result: got %h/%0d want 00000040/1",
               bus.r_data, bus.r_count);
    end
    accept();
  endtask

  task automatic test_job3(input int gap, input string name);
    push_pair(8'h08, 8'h08, 1'b0);
    repeat (gap) @(posedge clk);
    #1;
    push_pair(8'h10, 8'h08, 1'b0);
    repeat (gap) @(posedge clk);
    #1;
    push_pair(8'h88, 8'h08, 1'b1);
    wait_valid(50);
    n_checks++;
    if (bus.r_data !== 32'h80) begin
      n_fail++;
      $display("FAIL %s_data: got %h want 00000080", name, bus.r_data);
    end
    n_checks++;
    if (bus.r_count !== 8'd3 || bus.r_error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_cnt_err: got %0d/%b want 3/0",
               name, bus.r_count, bus.r_error);
    end
    accept();
  endtask

  task automatic test_high();
    push_pair(8'h7F, 8'h7F, 1'b1);
    wait_valid(50);
    n_checks++;
    if (bus.r_data !== 32'h1000_0000) begin
      n_fail++;
      $display("FAIL high_half: got %h want 10000000", bus.r_data);
    end
    accept();
  endtask

  task automatic test_error();
    push_pair(8'h08, 8'h08, 1'b0);
    mac_error = 1'b1;
    push_pair(8'h10, 8'h08, 1'b1);
    mac_error = 1'b0;
    wait_valid(50);
    n_checks++;
    if (bus.r_error !== 1'b1 || bus.r_data !== 32'hC0) begin
      n_fail++;
      $display("FAIL error_sticky: got %b/%h want 1/000000c0",
               bus.r_error, bus.r_data);
    end
    accept();
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 5; j++) begin
      int n;
      logic [31:0] sum;
      logic [7:0] a, b;
      n = int'($urandom_range(1, 12));
      sum = '0;
      for (int i = 0; i < n; i++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        sum += mf_prod(a, b);
        push_pair(a, b, i == n - 1);
      end
      wait_valid(50);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_checks++;
      if (bus.r_data !== sum) begin
        n_fail++;
        $display("FAIL rand%0d_data: got %h want %h", j, bus.r_data, sum);
      end
      n_checks++;
      if (bus.r_count !== 8'(n) || bus.r_error !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_cnt_err: got %0d/%b want %0d/0",
                 j, bus.r_count, bus.r_error, n);
      end
      accept();
    end
  endtask

  task automatic test_count_wrap();
    logic [31:0] sum;
    logic [7:0] a, b;
    sum = '0;
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      sum += mf_prod(a, b);
      push_pair(a, b, i == 255);
    end
    wait_valid(50);
    n_checks++;
    if (bus.r_count !== 8'd0 || bus.r_error !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_cnt_err: got %0d/%b want 0/0",
               bus.r_count, bus.r_error);
    end
    n_checks++;
    if (bus.r_data !== sum) begin
      n_fail++;
      $display("FAIL wrap_data: got %h want %h", bus.r_data, sum);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [31:0] s1, s2;
    int base;
    s1 = '0;
    s2 = '0;
    base = 0;
    for (int i = 0; i < 23; i++) begin
      qa.push_back(8'($urandom));
      qb.push_back(8'($urandom));
      if (i < 3) s1 += mf_prod(qa[i], qb[i]);
      else       s2 += mf_prod(qa[i], qb[i]);
    end
    fork
      begin
        for (int i = 0; i < 23; i++) begin
          push_pair(qa[i], qb[i], i == 2 || i == 22);
          if (i == 2) base = n_acc;
        end
      end
      begin
        wait_valid(100);
        repeat (20) @(negedge clk);
        n_checks++;
        if (bus.s_ready !== 1'b0 || n_acc - base != DEPTH) begin
          n_fail++;
          $display("FAIL b2b_full: s_ready %b buffered %0d want 0/%0d",
                   bus.s_ready, n_acc - base, DEPTH);
        end
        n_checks++;
        if (bus.r_data !== s1 || bus.r_count !== 8'd3) begin
          n_fail++;
          $display("FAIL b2b_job1: got %h/%0d want %h/3",
                   bus.r_data, bus.r_count, s1);
        end
        accept();
        wait_valid(200);
        n_checks++;
        if (bus.r_data !== s2 || bus.r_count !== 8'd20) begin
          n_fail++;
          $display("FAIL b2b_job2: got %h/%0d want %h/20",
                   bus.r_data, bus.r_count, s2);
        end
        accept();
      end
    join
  endtask

  task automatic test_reset_mid();
    logic ok;
    push_pair(8'h10, 8'h10, 1'b1);
    wait_valid(50);
    n_checks++;
    if (bus.r_data !== 32'h100) begin
      n_fail++;
      $display("FAIL mid_prev: got %h want 00000100", bus.r_data);
    end
    push_pair(8'h18, 8'h20, 1'b0);
    push_pair(8'h18, 8'h20, 1'b0);
    push_pair(8'h18, 8'h20, 1'b0);
    @(negedge clk);
    accept();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mac_reset !== 1'b1 || bus.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_in_reset: mac_reset %b s_ready %b want 1/0",
               mac_reset, bus.s_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (mac_a !== 8'h0 || mac_b !== 8'h0 || bus.r_valid !== 1'b0)
        ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_flush: stale issue or result, got %h %h %b",
               mac_a, mac_b, bus.r_valid);
    end
    push_pair(8'h08, 8'h08, 1'b1);
    wait_valid(50);
    n_checks++;
    if (bus.r_data !== 32'h40 || bus.r_count !== 8'd1) begin
      n_fail++;
      $display("FAIL mid_after: got %h/%0d want 00000040/1",
               bus.r_data, bus.r_count);
    end
    accept();
  endtask

  initial begin
    reset       = 1'b1;
    mac_error   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.s_last  = 1'b0;
    bus.r_ready = 1'b0;
    test_reset();
    test_single();
    test_job3(0, "job3");
    test_high();
    test_job3(5, "gaps");
    test_error();
    test_random_jobs();
    test_count_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
